// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types and helpers for the SRAM bus arbiter: FSM states, grant codes,
// the latched RAM command and the winner-selection rule.
package sram_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle   = 2'd0,
    ArbAccIf  = 2'd1,
    ArbAccMem = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GrantNone = 2'd0,
    GrantIf   = 2'd1,
    GrantMem  = 2'd2
  } grant_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } ram_cmd_t;

  localparam int         STARVE_W = 4;
  localparam logic [3:0] IF_SEL   = 4'hF;

  // MEM normally wins; a saturated starvation count hands the slot to a waiting IF.
  function automatic grant_t pick_grant(input logic if_elig, input logic mem_elig,
                                        input logic if_forced);
    if (mem_elig && !(if_forced && if_elig)) return GrantMem;
    if (if_elig) return GrantIf;
    return GrantNone;
  endfunction

endpackage

// File: rtl/sram_bus_arbiter_inst_buf.sv
// One-entry instruction buffer: word-tag lookup, fill on every SRAM fetch,
// invalidation when a MEM write lands on the buffered word.
module sram_bus_arbiter_inst_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] lookup_tag,
  output logic        hit,
  output logic [31:0] hit_data,
  input  logic        fill_en,
  input  logic [29:0] fill_tag,
  input  logic [31:0] fill_data,
  input  logic        inval_en,
  input  logic [29:0] inval_tag
);

  logic        valid_reg;
  logic [29:0] tag_reg;
  logic [31:0] data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      tag_reg   <= '0;
      data_reg  <= '0;
    end else if (fill_en) begin
      valid_reg <= 1'b1;
      tag_reg   <= fill_tag;
      data_reg  <= fill_data;
    end else if (inval_en && (inval_tag == tag_reg)) begin
      valid_reg <= 1'b0;
    end
  end

  assign hit      = valid_reg && (tag_reg == lookup_tag);
  assign hit_data = data_reg;

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares the RAMWrapper SRAM/UART port between instruction fetch and the MEM stage.
// Define ARB_INST_BUF_EN to add a one-entry instruction buffer in front of the fetch path.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int MAX_MEM_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_data_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_ack_o,
  output logic [31:0] mem_data_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  output logic        stall_req_o
);

  localparam logic [STARVE_W-1:0] MaxBurst = STARVE_W'(MAX_MEM_BURST);

  arb_state_t          state_reg;
  logic [STARVE_W-1:0] starve_cnt_reg;
  logic                if_elig;
  logic                mem_elig;
  logic                if_sram_elig;
  logic                buf_hit;
  logic [31:0]         buf_data;
  grant_t              grant;
  ram_cmd_t            cmd;

  // The ack cycle still shows the old request held high, so that requester sits out.
  assign if_elig      = if_req_i & ~if_ack_o;
  assign mem_elig     = mem_req_i & ~mem_ack_o;
  assign if_sram_elig = if_elig & ~buf_hit;
  assign stall_req_o  = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o);

`ifdef ARB_INST_BUF_EN
  logic buf_lookup_hit;

  sram_bus_arbiter_inst_buf u_inst_buf (
    .clk        (clk),
    .rst        (rst),
    .lookup_tag (if_addr_i[31:2]),
    .hit        (buf_lookup_hit),
    .hit_data   (buf_data),
    .fill_en    (state_reg == ArbAccIf),
    .fill_tag   (ram_addr_o[31:2]),
    .fill_data  (ram_rdata_i),
    .inval_en   ((state_reg == ArbAccMem) && ram_we_o),
    .inval_tag  (ram_addr_o[31:2])
  );

  assign buf_hit = (state_reg == ArbIdle) & if_elig & buf_lookup_hit;
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  always_comb begin
    grant = GrantNone;
    cmd   = '0;
    if (state_reg == ArbIdle) begin
      grant = pick_grant(if_sram_elig, mem_elig, starve_cnt_reg == MaxBurst);
    end
    if (grant == GrantIf) begin
      cmd = '{we: 1'b0, addr: if_addr_i, sel: IF_SEL, wdata: 32'h0};
    end else if (grant == GrantMem) begin
      cmd = '{we: mem_we_i, addr: mem_addr_i, sel: mem_sel_i, wdata: mem_data_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ArbIdle;
      ram_ce_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_sel_o   <= '0;
      ram_wdata_o <= '0;
      if_ack_o    <= 1'b0;
      mem_ack_o   <= 1'b0;
      if_data_o   <= '0;
      mem_data_o  <= '0;
    end else begin
      if_ack_o  <= 1'b0;
      mem_ack_o <= 1'b0;
      unique case (state_reg)
        ArbIdle: begin
          // A buffer hit answers IF directly and leaves the bus free for MEM.
          if (buf_hit) begin
            if_ack_o  <= 1'b1;
            if_data_o <= buf_data;
          end
          if (grant != GrantNone) begin
            state_reg   <= (grant == GrantIf) ? ArbAccIf : ArbAccMem;
            ram_ce_o    <= 1'b1;
            ram_we_o    <= cmd.we;
            ram_addr_o  <= cmd.addr;
            ram_sel_o   <= cmd.sel;
            ram_wdata_o <= cmd.wdata;
          end
        end
        ArbAccIf, ArbAccMem: begin
          if (state_reg == ArbAccIf) begin
            if_ack_o  <= 1'b1;
            if_data_o <= ram_rdata_i;
          end else begin
            mem_ack_o  <= 1'b1;
            mem_data_o <= ram_we_o ? 32'h0 : ram_rdata_i;
          end
          state_reg   <= ArbIdle;
          ram_ce_o    <= 1'b0;
          ram_we_o    <= 1'b0;
          ram_addr_o  <= '0;
          ram_sel_o   <= '0;
          ram_wdata_o <= '0;
        end
        default: state_reg <= ArbIdle;
      endcase
    end
  end

  // Counts MEM wins while IF waits; any IF service or an idle IF port resets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else if (!if_req_i || (grant == GrantIf) || buf_hit) begin
      starve_cnt_reg <= '0;
    end else if ((grant == GrantMem) && (starve_cnt_reg < MaxBurst)) begin
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: directed scenarios plus randomized
// traffic against a transaction-timing reference model (ARB_INST_BUF_EN aware).
module tb_sram_bus_arbiter;

  localparam int MAX_MEM_BURST = 4;
`ifdef ARB_INST_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_data_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic        mem_ack_o;
  logic [31:0] mem_data_o;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;
  logic        stall_req_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.MAX_MEM_BURST(MAX_MEM_BURST)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_data_o(if_data_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i),
    .mem_data_i(mem_data_i), .mem_ack_o(mem_ack_o), .mem_data_o(mem_data_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_sel_o(ram_sel_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .stall_req_o(stall_req_o)
  );

  // Memory image seen by the arbiter: one fixed word plus an address hash elsewhere.
  function automatic logic [31:0] ram_content(input logic [31:0] a);
    if (a == 32'h8000_0004) return 32'h3C01_1234;
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
  endfunction

  assign ram_rdata_i = ram_ce_o ? ram_content(ram_addr_o) : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0; mem_data_i = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    vectors++;
    if ({ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_ram: got ce=%b we=%b addr=%h sel=%h wdata=%h want all 0",
               ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o);
    end
    vectors++;
    if ({if_ack_o, mem_ack_o, if_data_o, mem_data_o, stall_req_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outs: got if_ack=%b mem_ack=%b if_data=%h mem_data=%h stall=%b want all 0",
               if_ack_o, mem_ack_o, if_data_o, mem_data_o, stall_req_o);
    end
  endtask

  task automatic test_single_if();
    apply_reset();
    if_req_i = 1'b1; if_addr_i = 32'h8000_0004;
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) tick();
      vectors++;
      if (if_ack_o !== (k == 2)) begin
        miscompares++;
        $display("FAIL single_if_ack k=%0d: got %b want %b", k, if_ack_o, (k == 2));
      end
      vectors++;
      if (ram_ce_o !== (k == 1)) begin
        miscompares++;
        $display("FAIL single_if_ce k=%0d: got %b want %b", k, ram_ce_o, (k == 1));
      end
      if (k == 1) begin
        vectors++;
        if ({ram_we_o, ram_addr_o, ram_sel_o} !== {1'b0, 32'h8000_0004, 4'hF}) begin
          miscompares++;
          $display("FAIL single_if_cmd: got we=%b addr=%h sel=%h want we=0 addr=80000004 sel=f",
                   ram_we_o, ram_addr_o, ram_sel_o);
        end
      end
      if (k == 2) begin
        vectors++;
        if (if_data_o !== 32'h3C01_1234) begin
          miscompares++;
          $display("FAIL single_if_data: got %h want 3c011234", if_data_o);
        end
        if_req_i = 1'b0;
      end
    end
  endtask

  task automatic test_if_mem_collision();
    apply_reset();
    if_req_i = 1'b1; if_addr_i = 32'h8000_0020;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h8040_0000;
    mem_sel_i = 4'b0011; mem_data_i = 32'h1122_3344;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      vectors++;
      if ({mem_ack_o, if_ack_o} !== {(k == 2), (k == 4)}) begin
        miscompares++;
        $display("FAIL collide_acks k=%0d: got mem=%b if=%b want mem=%b if=%b",
                 k, mem_ack_o, if_ack_o, (k == 2), (k == 4));
      end
      vectors++;
      if (ram_ce_o !== (k == 1 || k == 3)) begin
        miscompares++;
        $display("FAIL collide_ce k=%0d: got %b want %b", k, ram_ce_o, (k == 1 || k == 3));
      end
      if (k == 1) begin
        vectors++;
        if ({ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o} !==
            {1'b1, 32'h8040_0000, 4'b0011, 32'h1122_3344}) begin
          miscompares++;
          $display("FAIL collide_mem_cmd: got we=%b addr=%h sel=%h wdata=%h want 1/80400000/3/11223344",
                   ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o);
        end
      end
      if (k == 2) begin
        vectors++;
        if (mem_data_o !== 32'h0) begin
          miscompares++;
          $display("FAIL collide_wr_data: got %h want 0", mem_data_o);
        end
        mem_req_i = 1'b0;
      end
      if (k == 3) begin
        vectors++;
        if (ram_addr_o !== 32'h8000_0020) begin
          miscompares++;
          $display("FAIL collide_if_addr: got %h want 80000020", ram_addr_o);
        end
      end
      if (k == 4) begin
        vectors++;
        if (if_data_o !== ram_content(32'h8000_0020)) begin
          miscompares++;
          $display("FAIL collide_if_data: got %h want %h", if_data_o, ram_content(32'h8000_0020));
        end
        if_req_i = 1'b0;
      end
      #1;
      vectors++;
      if (stall_req_o !== (k <= 3)) begin
        miscompares++;
        $display("FAIL collide_stall k=%0d: got %b want %b", k, stall_req_o, (k <= 3));
      end
    end
  endtask

  task automatic test_uart_read();
    apply_reset();
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'hBFD0_03F8; mem_sel_i = 4'hF;
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) tick();
      if (k == 1) begin
        vectors++;
        if ({ram_ce_o, ram_we_o, ram_addr_o} !== {1'b1, 1'b0, 32'hBFD0_03F8}) begin
          miscompares++;
          $display("FAIL uart_cmd: got ce=%b we=%b addr=%h want 1/0/bfd003f8", ram_ce_o, ram_we_o, ram_addr_o);
        end
      end
      vectors++;
      if (mem_ack_o !== (k == 2)) begin
        miscompares++;
        $display("FAIL uart_ack k=%0d: got %b want %b", k, mem_ack_o, (k == 2));
      end
      if (k == 2) begin
        vectors++;
        if (mem_data_o !== ram_content(32'hBFD0_03F8)) begin
          miscompares++;
          $display("FAIL uart_data: got %h want %h", mem_data_o, ram_content(32'hBFD0_03F8));
        end
        mem_req_i = 1'b0;
      end
    end
  endtask

  // Both ports request continuously; the ack-cycle exclusion forces strict alternation.
  task automatic test_back_to_back();
    int n_if = 0;
    int n_mem = 0;
    apply_reset();
    if_req_i = 1'b1; if_addr_i = 32'h8000_1000;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h8000_2000; mem_sel_i = 4'hF;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) tick();
      vectors++;
      if ({mem_ack_o, if_ack_o} !== {(k >= 2 && k % 4 == 2), (k >= 4 && k % 4 == 0)}) begin
        miscompares++;
        $display("FAIL b2b_order k=%0d: got mem=%b if=%b want mem=%b if=%b", k, mem_ack_o, if_ack_o,
                 (k >= 2 && k % 4 == 2), (k >= 4 && k % 4 == 0));
      end
      if (if_ack_o === 1'b1) begin
        n_if++;
        if_addr_i = 32'h8000_1000 + 32'(n_if * 4);
      end
      if (mem_ack_o === 1'b1) begin
        n_mem++;
        mem_addr_i = 32'h8000_2000 + 32'(n_mem * 4);
      end
    end
    if_req_i = 1'b0; mem_req_i = 1'b0;
  endtask

`ifdef ARB_INST_BUF_EN
  task automatic test_inst_buf();
    apply_reset();
    if_req_i = 1'b1; if_addr_i = 32'h8000_0010;
    tick(); tick();
    vectors++;
    if (if_ack_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ibuf_first_ack: got %b want 1", if_ack_o);
    end
    if_req_i = 1'b0;
    tick();
    if_req_i = 1'b1;
    tick();
    vectors++;
    if ({if_ack_o, ram_ce_o, if_data_o} !== {1'b1, 1'b0, ram_content(32'h8000_0010)}) begin
      miscompares++;
      $display("FAIL ibuf_hit: got ack=%b ce=%b data=%h want ack=1 ce=0 data=%h",
               if_ack_o, ram_ce_o, if_data_o, ram_content(32'h8000_0010));
    end
    if_req_i = 1'b0;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h8000_0010; mem_sel_i = 4'hF;
    mem_data_i = 32'h0BAD_F00D;
    tick(); tick();
    vectors++;
    if (mem_ack_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ibuf_wr_ack: got %b want 1", mem_ack_o);
    end
    mem_req_i = 1'b0;
    tick();
    if_req_i = 1'b1;
    tick();
    vectors++;
    if ({if_ack_o, ram_ce_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL ibuf_refetch: got ack=%b ce=%b want ack=0 ce=1", if_ack_o, ram_ce_o);
    end
    tick();
    if_req_i = 1'b0;
  endtask
`endif

  task automatic test_random();
    int if_due = -1, mem_due = -1, acc_cyc = -1, free_at = 0, streak = 0;
    bit if_active = 0, mem_active = 0, acc_is_if = 0, acc_we = 0;
    logic [31:0] acc_addr = '0, acc_wdata = '0, if_exp = '0, mem_exp = '0;
    logic [3:0]  acc_sel = '0;
    bit bvalid = 0;
    logic [29:0] btag = '0;
    logic [31:0] bdata = '0;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      bit e_if, e_mem, if_el, mem_el, if_won, mem_won;
      if (c > 0) tick();
      e_if = (if_due == c);
      e_mem = (mem_due == c);
      vectors++;
      if ({if_ack_o, mem_ack_o} !== {e_if, e_mem}) begin
        miscompares++;
        $display("FAIL rand_acks c=%0d: got if=%b mem=%b want if=%b mem=%b", c, if_ack_o, mem_ack_o, e_if, e_mem);
      end
      if (e_if) begin
        vectors++;
        if (if_data_o !== if_exp) begin
          miscompares++;
          $display("FAIL rand_if_data c=%0d: got %h want %h", c, if_data_o, if_exp);
        end
      end
      if (e_mem) begin
        vectors++;
        if (mem_data_o !== mem_exp) begin
          miscompares++;
          $display("FAIL rand_mem_data c=%0d: got %h want %h", c, mem_data_o, mem_exp);
        end
      end
      vectors++;
      if (ram_ce_o !== (acc_cyc == c)) begin
        miscompares++;
        $display("FAIL rand_ce c=%0d: got %b want %b", c, ram_ce_o, (acc_cyc == c));
      end
      if (acc_cyc == c) begin
        vectors++;
        if ({ram_we_o, ram_addr_o, ram_sel_o} !== {acc_we, acc_addr, acc_sel} ||
            (acc_we && ram_wdata_o !== acc_wdata)) begin
          miscompares++;
          $display("FAIL rand_cmd c=%0d: got we=%b addr=%h sel=%h wdata=%h want we=%b addr=%h sel=%h wdata=%h",
                   c, ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o, acc_we, acc_addr, acc_sel, acc_wdata);
        end
        if (BUF_EN && acc_is_if) begin
          bvalid = 1; btag = acc_addr[31:2]; bdata = ram_content(acc_addr);
        end else if (BUF_EN && acc_we && btag == acc_addr[31:2]) begin
          bvalid = 0;
        end
      end
      if (e_if) if_active = 0;
      if (e_mem) mem_active = 0;
      if (!if_active && $urandom_range(0, 99) < 45) begin
        if_active = 1;
        if_addr_i = 32'h8000_0000 + 32'($urandom_range(0, 7) * 4);
      end
      if (!mem_active && $urandom_range(0, 99) < 45) begin
        mem_active = 1;
        mem_we_i = $urandom_range(0, 1) == 1;
        mem_addr_i = ($urandom_range(0, 4) == 0) ? 32'hBFD0_03F8 : 32'h8000_0000 + 32'($urandom_range(0, 15) * 4);
        mem_sel_i = 4'($urandom_range(1, 15));
        mem_data_i = $urandom;
      end
      if_req_i = if_active;
      mem_req_i = mem_active;
      #1;
      vectors++;
      if (stall_req_o !== ((if_req_i && !e_if) || (mem_req_i && !e_mem))) begin
        miscompares++;
        $display("FAIL rand_stall c=%0d: got %b want %b", c, stall_req_o, ((if_req_i && !e_if) || (mem_req_i && !e_mem)));
      end
      if_won = 0; mem_won = 0;
      if (c >= free_at) begin
        if_el = if_req_i && !e_if;
        mem_el = mem_req_i && !e_mem;
        if (BUF_EN && if_el && bvalid && btag == if_addr_i[31:2]) begin
          if_due = c + 1; if_exp = bdata; if_won = 1; if_el = 0;
        end
        if (mem_el && !(streak == MAX_MEM_BURST && if_el)) begin
          mem_won = 1; mem_due = c + 2;
          mem_exp = mem_we_i ? 32'h0 : ram_content(mem_addr_i);
          acc_is_if = 0; acc_we = mem_we_i; acc_addr = mem_addr_i; acc_sel = mem_sel_i; acc_wdata = mem_data_i;
        end else if (if_el) begin
          if_won = 1; if_due = c + 2; if_exp = ram_content(if_addr_i);
          acc_is_if = 1; acc_we = 0; acc_addr = if_addr_i; acc_sel = 4'hF; acc_wdata = '0;
        end
        if (mem_won || (if_won && if_due == c + 2)) begin
          acc_cyc = c + 1; free_at = c + 2;
        end
      end
      if (!if_req_i || if_won) streak = 0;
      else if (mem_won && streak < MAX_MEM_BURST) streak++;
    end
    if_req_i = 1'b0; mem_req_i = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    apply_reset();
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h8000_0040; mem_sel_i = 4'hF; mem_data_i = 32'hCAFE_0001;
    tick();
    vectors++;
    if (ram_ce_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_setup: got ce=%b want 1", ram_ce_o);
    end
    rst = 1'b1;
    tick();
    mem_req_i = 1'b0;
    vectors++;
    if ({ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o, if_ack_o, mem_ack_o, if_data_o, mem_data_o} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outs: got ce=%b we=%b addr=%h sel=%h wdata=%h mem_ack=%b want all 0",
               ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o, mem_ack_o);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if ({mem_ack_o, ram_ce_o} !== 2'b00) begin
        miscompares++;
        $display("FAIL rst_mid_no_ack k=%0d: got mem_ack=%b ce=%b want 0 0", k, mem_ack_o, ram_ce_o);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_if();
    test_if_mem_collision();
    test_uart_read();
    test_back_to_back();
`ifdef ARB_INST_BUF_EN
    test_inst_buf();
`endif
    test_random();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
